adbg_top_sel: RTL and testbench

- Parametrised next-generation top-level selector for the advanced debug interface.
- Owns the JTAG data-input shift register and the module-ID register, and drives one-hot module selects and the TDO mux across NB_MODULES debug sub-modules (AXI, CPU, future ones).
- Adds three features: out-of-range ID detection with a sticky error, deferred selection while a sub-module inhibits, and a readable status word when no module is selected.
- Sits between the TAP controller and the sub-modules, in the tck_i domain.

---
 rtl/adbg_top_sel.sv | 126 ++++++++++++
 tb/tb_adbg_top_sel.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adbg_top_sel.sv
// Top-level selector for the advanced debug interface: owns the JTAG input shift register
// and module-ID register, drives one-hot module selects, the TDO mux and a status word.
module adbg_top_sel #(
  parameter int NB_MODULES = 2,
  parameter int ID_WIDTH   = 5,
  parameter int DATA_LEN   = 64,
  parameter int DEFAULT_ID = 0
) (
  input  logic                  tck_i,
  input  logic                  trst_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  input  logic                  shift_dr_i,
  input  logic                  capture_dr_i,
  input  logic                  update_dr_i,
  input  logic                  debug_select_i,
  input  logic [NB_MODULES-1:0] module_tdo_i,
  input  logic [NB_MODULES-1:0] module_inhibit_i,
  output logic [NB_MODULES-1:0] module_select_o,
  output logic [DATA_LEN-1:0]   data_register_o,
  output logic [ID_WIDTH-1:0]   module_id_o,
  output logic                  id_valid_o,
  output logic                  select_error_o
);

  localparam int                ST_W         = ID_WIDTH + 3;
  localparam logic [ID_WIDTH:0] NB_MOD_L     = (ID_WIDTH + 1)'(NB_MODULES);
  localparam logic [ID_WIDTH-1:0] DEFAULT_ID_L = ID_WIDTH'(DEFAULT_ID);

  logic [DATA_LEN-1:0]   sr_r;
  logic [ID_WIDTH-1:0]   module_id_r;
  logic                  id_valid_r;
  logic                  pending_valid_r;
  logic [ID_WIDTH-1:0]   pending_id_r;
  logic                  select_error_r;
  logic [ST_W-1:0]       status_sr_r;

  logic                  sel_cmd_s;
  logic [ID_WIDTH-1:0]   id_in_s;
  logic                  inhibit_s;
  logic                  id_oor_s;
  logic                  do_shift_s;
  logic                  do_update_s;
  logic                  do_capture_s;
  logic                  do_apply_s;
  logic [NB_MODULES-1:0] module_select_s;

  assign sel_cmd_s    = sr_r[DATA_LEN-1];
  assign id_in_s      = sr_r[DATA_LEN-2 -: ID_WIDTH];
  assign inhibit_s    = |module_inhibit_i;
  assign id_oor_s     = ({1'b0, id_in_s} >= NB_MOD_L);
  assign do_shift_s   = debug_select_i & shift_dr_i;
  assign do_update_s  = debug_select_i & update_dr_i & sel_cmd_s;
  assign do_capture_s = debug_select_i & capture_dr_i & ~id_valid_r;
  // Deferred apply ignores debug_select_i but must not collide with a shift or update.
  assign do_apply_s   = pending_valid_r & ~inhibit_s & ~shift_dr_i & ~update_dr_i;

  // Shift register, module selection, pending request, sticky error and status word.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      sr_r            <= '0;
      module_id_r     <= DEFAULT_ID_L;
      id_valid_r      <= 1'b1;
      pending_valid_r <= 1'b0;
      pending_id_r    <= '0;
      select_error_r  <= 1'b0;
      status_sr_r     <= '0;
    end else begin
      if (do_shift_s) begin
        sr_r <= {tdi_i, sr_r[DATA_LEN-1:1]};
      end

      if (do_update_s) begin
        if (id_oor_s) begin
          id_valid_r      <= 1'b0;
          module_id_r     <= id_in_s;
          pending_valid_r <= 1'b0;
        end else if (inhibit_s) begin
          pending_id_r    <= id_in_s;
          pending_valid_r <= 1'b1;
        end else begin
          module_id_r     <= id_in_s;
          id_valid_r      <= 1'b1;
          pending_valid_r <= 1'b0;
        end
      end else if (do_apply_s) begin
        module_id_r     <= pending_id_r;
        id_valid_r      <= 1'b1;
        pending_valid_r <= 1'b0;
      end

      // A new error outranks the read-to-clear of a simultaneous capture.
      if (do_update_s && id_oor_s) begin
        select_error_r <= 1'b1;
      end else if (do_capture_s) begin
        select_error_r <= 1'b0;
      end

      if (do_capture_s) begin
        status_sr_r <= {pending_id_r, pending_valid_r, select_error_r, 1'b1};
      end else if (do_shift_s && !id_valid_r) begin
        status_sr_r <= {1'b0, status_sr_r[ST_W-1:1]};
      end
    end
  end

  // One-hot select decode and TDO mux.
  always_comb begin
    module_select_s = '0;
    for (int k = 0; k < NB_MODULES; k++) begin
      module_select_s[k] = id_valid_r & (module_id_r == ID_WIDTH'(k));
    end
    if (id_valid_r) begin
      tdo_o = |(module_tdo_i & module_select_s);
    end else begin
      tdo_o = status_sr_r[0];
    end
  end

  assign module_select_o = module_select_s;
  assign data_register_o = sr_r;
  assign module_id_o     = module_id_r;
  assign id_valid_o      = id_valid_r;
  assign select_error_o  = select_error_r;

endmodule

// File: tb/tb_adbg_top_sel.sv
// Directed bench for adbg_top_sel: expected values queued at stimulus time, popped at check time.
module tb_adbg_top_sel;

  logic        tck;
  logic        trst;
  logic        tdi;
  logic        tdo;
  logic        shift_dr;
  logic        capture_dr;
  logic        update_dr;
  logic        debug_select;
  logic [1:0]  module_tdo;
  logic [1:0]  module_inhibit;
  logic [1:0]  module_select;
  logic [63:0] data_register;
  logic [4:0]  module_id;
  logic        id_valid;
  logic        select_error;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  adbg_top_sel #(
    .NB_MODULES(2), .ID_WIDTH(5), .DATA_LEN(64), .DEFAULT_ID(0)
  ) dut (
    .tck_i(tck), .trst_i(trst), .tdi_i(tdi), .tdo_o(tdo),
    .shift_dr_i(shift_dr), .capture_dr_i(capture_dr), .update_dr_i(update_dr),
    .debug_select_i(debug_select), .module_tdo_i(module_tdo),
    .module_inhibit_i(module_inhibit), .module_select_o(module_select),
    .data_register_o(data_register), .module_id_o(module_id),
    .id_valid_o(id_valid), .select_error_o(select_error)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic exp_push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic shift_frame(input logic [63:0] f);
    shift_dr = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tdi = f[i];
      tick();
    end
    shift_dr = 1'b0;
    tdi      = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  function automatic logic [63:0] sel_frame(input logic [4:0] id);
    return {1'b1, id, 58'd0};
  endfunction

  logic [7:0]  st_exp;
  logic [63:0] data_frame;

  initial begin
    trst = 1'b1; tdi = 1'b0; shift_dr = 1'b0; capture_dr = 1'b0; update_dr = 1'b0;
    debug_select = 1'b0; module_tdo = 2'b01; module_inhibit = 2'b00;
    #2;
    exp_push("rst_select", 64'h1);   check({62'd0, module_select});
    exp_push("rst_id", 64'h0);       check({59'd0, module_id});
    exp_push("rst_valid", 64'h1);    check({63'd0, id_valid});
    exp_push("rst_error", 64'h0);    check({63'd0, select_error});
    exp_push("rst_data", 64'h0);     check(data_register);
    exp_push("rst_tdo", 64'h1);      check({63'd0, tdo});
    #10;
    trst = 1'b0;
    debug_select = 1'b1;

    // Select module 1
    shift_frame(sel_frame(5'd1));
    update();
    exp_push("sel1_select", 64'h2);  check({62'd0, module_select});
    exp_push("sel1_id", 64'h1);      check({59'd0, module_id});
    module_tdo = 2'b10; #1;
    exp_push("sel1_tdo_hi", 64'h1);  check({63'd0, tdo});
    module_tdo = 2'b01; #1;
    exp_push("sel1_tdo_lo", 64'h0);  check({63'd0, tdo});

    // Out-of-range ID 7, then read status
    shift_frame(sel_frame(5'd7));
    update();
    exp_push("oor_valid", 64'h0);    check({63'd0, id_valid});
    exp_push("oor_select", 64'h0);   check({62'd0, module_select});
    exp_push("oor_error", 64'h1);    check({63'd0, select_error});
    exp_push("oor_id", 64'h7);       check({59'd0, module_id});
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    exp_push("cap_error_clr", 64'h0); check({63'd0, select_error});
    st_exp = 8'b0000_0011;
    for (int i = 0; i < 8; i++) begin
      exp_push($sformatf("status_bit%0d", i), {63'd0, st_exp[i]});
      check({63'd0, tdo});
      if (i < 7) begin
        shift_dr = 1'b1;
        tick();
        shift_dr = 1'b0;
      end
    end

    // Recover to module 0, then deferred select of module 1
    shift_frame(sel_frame(5'd0));
    update();
    exp_push("rec0_select", 64'h1);  check({62'd0, module_select});
    module_inhibit = 2'b01;
    shift_frame(sel_frame(5'd1));
    update();
    exp_push("inh_hold", 64'h1);     check({62'd0, module_select});
    tick();
    exp_push("inh_idle", 64'h1);     check({62'd0, module_select});
    module_inhibit = 2'b00; #1;
    exp_push("inh_drop_0", 64'h1);   check({62'd0, module_select});
    tick();
    exp_push("inh_apply", 64'h2);    check({62'd0, module_select});

    // Pending request overwritten before inhibit drops
    module_inhibit = 2'b10;
    shift_frame(sel_frame(5'd1));
    update();
    shift_frame(sel_frame(5'd0));
    update();
    exp_push("ovw_hold", 64'h2);     check({62'd0, module_select});
    module_inhibit = 2'b00;
    tick();
    exp_push("ovw_apply", 64'h1);    check({62'd0, module_select});
    tick();
    exp_push("ovw_stable", 64'h1);   check({62'd0, module_select});

    // Update ignored without DEBUG instruction
    shift_frame(sel_frame(5'd1));
    debug_select = 1'b0;
    update();
    exp_push("nodbg_id", 64'h0);     check({59'd0, module_id});
    debug_select = 1'b1;
    update();
    exp_push("dbg_id", 64'h1);       check({59'd0, module_id});

    // Data frame (no select command)
    data_frame = 64'h2345_6789_ABCD_EF01;
    shift_frame(data_frame);
    update();
    exp_push("data_id", 64'h1);      check({59'd0, module_id});
    exp_push("data_reg", data_frame); check(data_register);

    // Asynchronous reset mid-shift
    shift_frame(sel_frame(5'd9));
    update();
    exp_push("pre_rst_error", 64'h1); check({63'd0, select_error});
    shift_dr = 1'b1;
    tdi      = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    trst = 1'b1;
    #1;
    exp_push("arst_select", 64'h1);  check({62'd0, module_select});
    exp_push("arst_id", 64'h0);      check({59'd0, module_id});
    exp_push("arst_valid", 64'h1);   check({63'd0, id_valid});
    exp_push("arst_error", 64'h0);   check({63'd0, select_error});
    exp_push("arst_data", 64'h0);    check(data_register);
    #2;
    trst     = 1'b0;
    shift_dr = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
